// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and external
// stalls for the IF/ID and ID/EX registers, with saturating stall/flush counters.
module hazard_ctrl #(
    parameter int LOAD_USE_PENALTY = 1,
    parameter int FLUSH_CYCLES     = 1,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_mem_read,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, FLUSH = 2'd2, ST_BAD = 2'd3} state_t;

    // The entry cycle is itself a penalty cycle, so the counter loads N-2.
    localparam logic [2:0] LU_LOAD = (LOAD_USE_PENALTY > 1) ? 3'(LOAD_USE_PENALTY - 2) : 3'd0;
    localparam logic [2:0] FL_LOAD = (FLUSH_CYCLES > 1)     ? 3'(FLUSH_CYCLES - 2)     : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     st, st_nxt;
    logic [2:0] pcnt, pcnt_nxt;
    logic       stall_inc, flush_inc;
    logic       hz;

    assign hz = idex_mem_read && (idex_rd != 5'd0) &&
                ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    assign state = st;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st          <= RUN;
            pcnt        <= 3'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            st   <= st_nxt;
            pcnt <= pcnt_nxt;
            if (stall_inc && stall_count != CNT_MAX)
                stall_count <= stall_count + CNT_W'(1);
            if (flush_inc && flush_count != CNT_MAX)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    always_comb begin
        st_nxt    = st;
        pcnt_nxt  = pcnt;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (ext_stall) begin
            // frozen: penalty resumes where it left off
        end else if (branch_taken) begin
            flush_inc = 1'b1;
            st_nxt    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            pcnt_nxt  = FL_LOAD;
        end else begin
            case (st)
                RUN: begin
                    if (hz) begin
                        stall_inc = 1'b1;
                        st_nxt    = (LOAD_USE_PENALTY > 1) ? LSTALL : RUN;
                        pcnt_nxt  = LU_LOAD;
                    end
                end
                LSTALL: begin
                    stall_inc = 1'b1;
                    if (pcnt == 3'd0) st_nxt = RUN;
                    else              pcnt_nxt = pcnt - 3'd1;
                end
                FLUSH: begin
                    if (pcnt == 3'd0) st_nxt = RUN;
                    else              pcnt_nxt = pcnt - 3'd1;
                end
                default: begin
                    st_nxt   = RUN;
                    pcnt_nxt = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        if (!rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ext_stall) begin
            idex_hold = 1'b1;
        end else if (branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (st)
                RUN: begin
                    if (hz) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                LSTALL: idex_bubble = 1'b1;
                FLUSH: begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                // Unreachable encoding: hold the front end and bubble until recovered.
                default: idex_bubble = 1'b1;
            endcase
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller; the control-side counterpart of the IF/ID and ID/EX pipeline registers. It issues write-enable, flush and bubble commands to those registers.
- Detects load-use hazards between the ID instruction and the EX instruction, handles taken-branch flushes and external memory stalls.
- Sequences multi-cycle stall and flush penalties with a small FSM.
- Keeps saturating performance counters for stall and flush events.

Parameters:
- LOAD_USE_PENALTY, 1, bubble cycles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken branch (1..7).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- ifid_rs1  in  5  rs1 field of the instruction in ID.
- ifid_rs2  in  5  rs2 field of the instruction in ID.
- idex_rd  in  5  rd of the instruction in EX.
- idex_mem_read  in  1  the instruction in EX is a load.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- ext_stall  in  1  memory not ready; freeze the whole pipeline.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  zero IF/ID contents at next edge.
- idex_bubble  out  1  load zeros into ID/EX control fields at next edge.
- idex_hold  out  1  ID/EX holds its current contents.
- state  out  2  FSM state: 0 RUN, 1 LSTALL, 2 FLUSH.
- stall_count  out  CNT_W  load-use bubble cycles inserted.
- flush_count  out  CNT_W  taken-branch events accepted.

Behaviour:
- Sequential elements: state, 3-bit penalty counter pcnt, stall_count, flush_count. Command outputs are combinational (Mealy) from state and inputs.
- Hazard condition: hz = idex_mem_read && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2).
- Reset (rst=0 at a rising edge): state=RUN, pcnt=0, both counters=0. While rst=0, the outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, idex_hold=0. Reset mid-stall or mid-flush aborts immediately.
- Priority when rst=1: ext_stall > branch_taken > state-driven penalty > hz > normal.
- ext_stall=1:
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, idex_hold=1.
  - state, pcnt and counters are frozen. The penalty resumes when ext_stall drops.
- branch_taken=1 (any state, no ext_stall):
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, idex_hold=0.
  - flush_count increments.
  - Next state: if FLUSH_CYCLES>1, go to FLUSH with pcnt=FLUSH_CYCLES-2; otherwise go to RUN.
  - A pending LSTALL is abandoned.
- FLUSH state:
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
  - If pcnt==0, go to RUN; otherwise pcnt decrements.
  - hz is ignored in this state.
- LSTALL state:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - stall_count increments.
  - If pcnt==0, go to RUN; otherwise pcnt decrements.
- RUN with hz=1:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - stall_count increments.
  - Next state: if LOAD_USE_PENALTY>1, go to LSTALL with pcnt=LOAD_USE_PENALTY-2; otherwise stay in RUN.
- RUN with no event: pc_write=1, ifid_write=1, all other commands 0.
- Total bubbles per hazard = LOAD_USE_PENALTY. Total flush cycles per branch = FLUSH_CYCLES.
- Counters saturate at 2^CNT_W-1; they never wrap.
- x0 never triggers a hazard (idex_rd==0 excluded).
- Encoding 3 of state is unreachable. If it is ever entered, the next edge goes to RUN.

Test Plan:
- Release rst with idle inputs: first cycle after release shows pc_write=1, ifid_write=1, state=0, stall_count=0, flush_count=0. While rst=0, ifid_flush=1 and idex_bubble=1.
- LOAD_USE_PENALTY=1; idex_mem_read=1, idex_rd=5, ifid_rs2=5 for one cycle: pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_count=1; state stays 0. Repeat with idex_rd=0: no stall.
- LOAD_USE_PENALTY=3; hazard on rs1=7: 3 consecutive bubble cycles, state=1 for cycles 2-3, stall_count=3. Holding ext_stall=1 during cycle 2 for 4 cycles gives idex_hold=1, state frozen, and still exactly 3 bubbles in total.
- FLUSH_CYCLES=2; branch_taken pulse: ifid_flush=1 and idex_bubble=1 for 2 cycles, pc_write=1 throughout, flush_count=1. A branch_taken coinciding with hz: flush wins, stall_count unchanged.
- Reset asserted while state=1 with pcnt=1: the next edge gives state=0 and counters=0; after release, normal flow with no residual bubble.
- Saturation with CNT_W=4: 20 hazard cycles leave stall_count=15.
